// File: rtl/home_ctrl_pkg.sv
// Shared types and constants for the second-generation home controller.
package home_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ALARM      = 2'd1,
    ALARM_HOLD = 2'd2
  } state_e;

  localparam logic [2:0] DISP_NONE  = 3'd0;
  localparam logic [2:0] DISP_ALARM = 3'd1;
  localparam logic [2:0] DISP_WIN   = 3'd2;
  localparam logic [2:0] DISP_DOOR  = 3'd3;
  localparam logic [2:0] DISP_HEAT  = 3'd4;
  localparam logic [2:0] DISP_COOL  = 3'd5;

endpackage

// File: rtl/hc_debounce.sv
// Single-bit debouncer: the clean value flips only after DEBOUNCE consecutive
// samples that differ from it.
module hc_debounce
  import home_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic raw,
  output logic clean
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;

  // Count disagreeing samples; any agreeing sample restarts the run.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (raw != clean_q) begin
      if (cnt_q == LAST) begin
        clean_d = ~clean_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/home_ctrl_gen2.sv
// Home controller top: sensor debouncing, fire-alarm supervisory FSM,
// climate hysteresis and registered actuator/display outputs.
module home_ctrl_gen2
  import home_ctrl_pkg::*;
#(
  parameter int N_DOOR   = 2,
  parameter int N_WIN    = 1,
  parameter int TEMP_W   = 7,
  parameter int T_LOW    = 50,
  parameter int T_HIGH   = 60,
  parameter int HYST     = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_DOOR-1:0] SD,
  input  logic [N_WIN-1:0]  SW,
  input  logic              SFA,
  input  logic [TEMP_W-1:0] ST,
  input  logic              ack,
  output logic [N_DOOR-1:0] door,
  output logic              winbuzz,
  output logic              alarmbuzz,
  output logic              heater,
  output logic              cooler,
  output logic [2:0]        display
);

  localparam int XW = TEMP_W + 1;
  localparam logic [XW-1:0] HEAT_ON  = XW'(T_LOW);
  localparam logic [XW-1:0] HEAT_OFF = XW'(T_LOW + HYST);
  localparam logic [XW-1:0] COOL_ON  = XW'(T_HIGH);
  localparam logic [XW-1:0] COOL_OFF = XW'(T_HIGH - HYST);

  logic [N_DOOR-1:0] sd_db;
  logic [N_WIN-1:0]  sw_db;
  logic              sfa_db;

  for (genvar i = 0; i < N_DOOR; i++) begin : g_door
    hc_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (.Clk(Clk), .Rst(Rst), .raw(SD[i]), .clean(sd_db[i]));
  end
  for (genvar j = 0; j < N_WIN; j++) begin : g_win
    hc_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (.Clk(Clk), .Rst(Rst), .raw(SW[j]), .clean(sw_db[j]));
  end
  hc_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_fire (.Clk(Clk), .Rst(Rst), .raw(SFA), .clean(sfa_db));

  state_e            state_q, state_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic              heat_q, heat_d, cool_q, cool_d;
  logic [N_DOOR-1:0] door_q, door_d;
  logic              win_q, win_d, alarm_q, alarm_d;
  logic [2:0]        disp_q, disp_d;
  logic [XW-1:0]     temp_x;

  assign temp_x = {1'b0, temp_q};

  // Outputs are derived from the next state so they switch on the same edge as the FSM.
  always_comb begin
    temp_d = ST;
    case (state_q)
      IDLE:       if (sfa_db) state_d = ALARM;      else state_d = IDLE;
      ALARM:      if (!sfa_db) state_d = ALARM_HOLD; else state_d = ALARM;
      ALARM_HOLD: if (sfa_db) state_d = ALARM;
                  else if (ack) state_d = IDLE;
                  else state_d = ALARM_HOLD;
      default:    state_d = IDLE;
    endcase

    // Flags only evolve while idle on both sides of the edge, so a return starts from zero.
    if ((state_q == IDLE) && (state_d == IDLE)) begin
      if (temp_x < HEAT_ON) heat_d = 1'b1;
      else if (temp_x >= HEAT_OFF) heat_d = 1'b0;
      else heat_d = heat_q;
      if (temp_x > COOL_ON) cool_d = 1'b1;
      else if (temp_x <= COOL_OFF) cool_d = 1'b0;
      else cool_d = cool_q;
    end else begin
      heat_d = 1'b0;
      cool_d = 1'b0;
    end

    win_d = |sw_db;
    if (state_d == IDLE) begin
      door_d  = sd_db;
      alarm_d = 1'b0;
    end else begin
      door_d  = {N_DOOR{1'b1}};
      alarm_d = 1'b1;
    end

    if (alarm_d) disp_d = DISP_ALARM;
    else if (win_d) disp_d = DISP_WIN;
    else if (|door_d) disp_d = DISP_DOOR;
    else if (heat_d) disp_d = DISP_HEAT;
    else if (cool_d) disp_d = DISP_COOL;
    else disp_d = DISP_NONE;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      temp_q  <= '0;
      heat_q  <= 1'b0;
      cool_q  <= 1'b0;
      door_q  <= '0;
      win_q   <= 1'b0;
      alarm_q <= 1'b0;
      disp_q  <= DISP_NONE;
    end else begin
      state_q <= state_d;
      temp_q  <= temp_d;
      heat_q  <= heat_d;
      cool_q  <= cool_d;
      door_q  <= door_d;
      win_q   <= win_d;
      alarm_q <= alarm_d;
      disp_q  <= disp_d;
    end
  end

  assign door      = door_q;
  assign winbuzz   = win_q;
  assign alarmbuzz = alarm_q;
  assign heater    = heat_q;
  assign cooler    = cool_q;
  assign display   = disp_q;

endmodule

// File: tb/tb_home_ctrl_gen2.sv
// Scoreboard bench for home_ctrl_gen2: default configuration, then the
// N_DOOR=4 / N_WIN=3 / DEBOUNCE=1 / TEMP_W=8 configuration.
module tb_home_ctrl_gen2;

  typedef struct {
    int          cyc;
    logic [10:0] val;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sd;
  logic [2:0] sw;
  logic       sfa, ack;
  logic [7:0] st;

  logic [1:0] door_a;
  logic       wb_a, ab_a, ht_a, cl_a;
  logic [2:0] disp_a;
  logic [3:0] door_b;
  logic       wb_b, ab_b, ht_b, cl_b;
  logic [2:0] disp_b;

  int          cyc = 0;
  int          phase = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb_q[$];
  exp_t        item;
  logic [10:0] act;

  home_ctrl_gen2 #(.N_DOOR(2), .N_WIN(1), .TEMP_W(7), .T_LOW(50), .T_HIGH(60),
                   .HYST(2), .DEBOUNCE(4)) u_dut_a (
    .Clk(clk), .Rst(rst), .SD(sd[1:0]), .SW(sw[0:0]), .SFA(sfa), .ST(st[6:0]), .ack(ack),
    .door(door_a), .winbuzz(wb_a), .alarmbuzz(ab_a), .heater(ht_a), .cooler(cl_a),
    .display(disp_a));

  home_ctrl_gen2 #(.N_DOOR(4), .N_WIN(3), .TEMP_W(8), .T_LOW(50), .T_HIGH(60),
                   .HYST(2), .DEBOUNCE(1)) u_dut_b (
    .Clk(clk), .Rst(rst), .SD(sd), .SW(sw), .SFA(sfa), .ST(st), .ack(ack),
    .door(door_b), .winbuzz(wb_b), .alarmbuzz(ab_b), .heater(ht_b), .cooler(cl_b),
    .display(disp_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    if (phase == 0) act = {2'b00, door_a, wb_a, ab_a, ht_a, cl_a, disp_a};
    else            act = {door_b, wb_b, ab_b, ht_b, cl_b, disp_b};
  end

  // Monitor: every expectation is checked at the negedge of its cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      item = sb_q.pop_front();
      n_cmp++;
      if (item.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s (cfg %0d): check due at cycle %0d seen at cycle %0d", item.name, phase, item.cyc, cyc);
      end else if (act !== item.val) begin
        n_bad++;
        $display("FAIL %s (cfg %0d) cycle %0d: got door/wb/ab/ht/cl/disp=%b expected %b",
                 item.name, phase, cyc, act, item.val);
      end
    end
  end

  function automatic logic [10:0] ev(input logic [3:0] d, input logic wb, input logic ab,
                                      input logic ht, input logic cl, input logic [2:0] ds);
    return {d, wb, ab, ht, cl, ds};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_push(input int off, input string nm, input logic [10:0] v);
    exp_t e;
    e.cyc  = cyc + off;
    e.val  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; sd = 4'd0; sw = 3'd0; sfa = 1'b0; ack = 1'b0; st = 8'd55;
    sb_push(1, "reset", 11'd0);
    step(2);
    rst = 1'b0;
    sb_push(3, "post_reset_idle", 11'd0);
    step(3);
  endtask

  task automatic run_suite(input int d, input logic [3:0] m);
    logic [3:0]  one = 4'b0001;
    logic [10:0] alarm_v;
    logic [10:0] prev;
    int          tv[9]  = '{49, 51, 52, 61, 59, 58, 50, 60, 49};
    logic [1:0]  thc[9] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    logic [2:0]  tds[9] = '{3'd4, 3'd4, 3'd0, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 3'd4};
    alarm_v = ev(m, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);

    do_reset();

    // Door open / close, then a too-short pulse.
    sd = 4'b0001;
    sb_push(d, "door_latency", 11'd0);
    sb_push(d + 1, "door_open", ev(one, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
    step(d + 1);
    sd = 4'b0000;
    sb_push(d + 1, "door_close", 11'd0);
    step(d + 1);
    if (d > 1) begin
      for (int k = 1; k <= 2 * d + 1; k++) sb_push(k, "door_pulse", 11'd0);
      sd = 4'b0001;
      step(d - 1);
      sd = 4'b0000;
      step(d + 3);
    end

    // Window alone, then window beating door in the display priority.
    sw = 3'b001;
    sb_push(d + 1, "win_open", ev(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2));
    step(d + 1);
    sd = 4'b0001;
    sb_push(d + 1, "win_over_door", ev(one, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2));
    step(d + 1);
    sw = 3'd0; sd = 4'd0;
    sb_push(d + 1, "win_door_close", 11'd0);
    step(d + 1);

    // Temperature hysteresis walk; each step checks old value then new value.
    prev = 11'd0;
    for (int i = 0; i < 9; i++) begin
      st = tv[i][7:0];
      sb_push(1, "hyst_latency", prev);
      prev = ev(4'd0, 1'b0, 1'b0, thc[i][1], thc[i][0], tds[i]);
      sb_push(2, "hyst", prev);
      step(2);
    end

    // Fire while heating: heater drops, doors evacuate.
    sfa = 1'b1;
    sb_push(d, "fire_latency", ev(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4));
    sb_push(d + 1, "fire_alarm", alarm_v);
    step(d + 1);
    ack = 1'b1;
    sb_push(1, "ack_in_alarm", alarm_v);
    step(1);
    ack = 1'b0;
    sfa = 1'b0; sd = 4'b0001;
    sb_push(d + 1, "alarm_hold", alarm_v);
    step(d + 1);
    ack = 1'b1;
    sb_push(1, "ack_release", ev(one, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
    sb_push(2, "heat_resume", ev(one, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3));
    step(1);
    ack = 1'b0;
    step(1);

    // Re-assert in hold on the same edge as ack: alarm must win.
    sfa = 1'b1;
    sb_push(d + 1, "realarm", alarm_v);
    step(d + 1);
    sfa = 1'b0;
    sb_push(d + 1, "rehold", alarm_v);
    step(d + 1);
    sfa = 1'b1;
    step(d);
    ack = 1'b1;
    sb_push(1, "reassert_vs_ack", alarm_v);
    sb_push(3, "reassert_stays", alarm_v);
    step(1);
    ack = 1'b0;
    step(2);

    // Reset in the middle of an alarm.
    do_reset();
    step(2);
  endtask

  initial begin
    rst = 1'b1; sd = 4'd0; sw = 3'd0; sfa = 1'b0; ack = 1'b0; st = 8'd55;
    for (int p = 0; p < 2; p++) begin
      phase = p;
      step(1);
      if (p == 0) run_suite(4, 4'b0011);
      else        run_suite(1, 4'b1111);
    end
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step(1);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
